// File: rtl/stream_arb_mux.sv
// Stream arbiter/mux: picks one of NUM_IN valid/ready channels (fixed select or
// round-robin) and registers the winner into a single output stage.
module stream_arb_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SEL_W-1:0]        out_sel
);

    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic             out_valid_q, out_valid_d;

    logic             gnt_vld;
    logic [SEL_W-1:0] gnt_idx;
    logic [WIDTH-1:0] gnt_data;
    logic             reg_free;
    logic             xfer;

    function automatic logic [SEL_W-1:0] rr_idx(input logic [SEL_W-1:0] ptr, input int k);
        return SEL_W'((int'(ptr) + k) % NUM_IN);
    endfunction

    // Fixed mode only looks at in_valid[sel]; an out-of-range sel matches no channel.
    // Round-robin walks downward in k so the lowest offset from rr_ptr wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (!mode) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (sel == SEL_W'(i) && in_valid[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = SEL_W'(i);
                end
            end
        end else begin
            for (int k = NUM_IN - 1; k >= 0; k--) begin
                if (in_valid[rr_idx(rr_ptr_q, k)]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = rr_idx(rr_ptr_q, k);
                end
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (gnt_idx == SEL_W'(i)) gnt_data = in_data[i*WIDTH +: WIDTH];
        end
    end

    assign reg_free = !out_valid_q || out_ready;
    assign xfer     = rst_n && reg_free && gnt_vld;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (xfer && gnt_idx == SEL_W'(i)) in_ready[i] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        if (reg_free) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = gnt_data;
                out_sel_d  = gnt_idx;
            end
        end
        if (xfer && mode) begin
            rr_ptr_d = (gnt_idx == SEL_W'(NUM_IN - 1)) ? '0 : gnt_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= '0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed bench: a 4-channel instance for pass-through, round-robin, backpressure,
// wrap and reset; a 3-channel instance for out-of-range select and mod-3 wrap.
module tb_stream_arb_mux;

    logic clk;
    logic rst_n;

    logic           a_mode, a_out_ready, a_out_valid;
    logic [1:0]     a_sel, a_out_sel;
    logic [127:0]   a_in_data;
    logic [3:0]     a_in_valid, a_in_ready;
    logic [31:0]    a_out_data;

    logic           b_mode, b_out_ready, b_out_valid;
    logic [1:0]     b_sel, b_out_sel;
    logic [23:0]    b_in_data;
    logic [2:0]     b_in_valid, b_in_ready;
    logic [7:0]     b_out_data;

    int n_tests = 0;
    int n_fail  = 0;

    stream_arb_mux #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) u_a (
        .clk(clk), .rst_n(rst_n), .mode(a_mode), .sel(a_sel),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_sel(a_out_sel)
    );

    stream_arb_mux #(.WIDTH(8), .NUM_IN(3), .SEL_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .mode(b_mode), .sel(b_sel),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_sel(b_out_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        a_mode      = 1'b0;
        a_sel       = 2'd0;
        a_in_valid  = 4'b1111;
        a_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) a_in_data[i*32 +: 32] = 32'hCAFE0000 | i;
        b_mode      = 1'b0;
        b_sel       = 2'd1;
        b_in_valid  = 3'b111;
        b_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) b_in_data[i*8 +: 8] = 8'hA0 | 8'(i);

        // Reset state, with valid inputs present
        step();
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data",  a_out_data, 0);
        chk("rst_out_sel",   a_out_sel, 0);
        chk("rst_in_ready",  a_in_ready, 0);
        chk("rst_b_in_ready", b_in_ready, 0);
        rst_n = 1'b1;

        // Fixed-mode pass-through
        a_sel = 2'd2;
        #1 chk("fix_in_ready", a_in_ready, 4'b0100);
        step();
        chk("fix_out_data",  a_out_data, 32'hCAFE0002);
        chk("fix_out_sel",   a_out_sel, 2);
        chk("fix_out_valid", a_out_valid, 1);

        // Round-robin from rr_ptr=0 (fixed mode left it untouched)
        a_mode = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1 chk("rr_in_ready", a_in_ready, 4'b0001 << (k % 4));
            step();
            chk("rr_out_sel",   a_out_sel, k % 4);
            chk("rr_out_data",  a_out_data, 32'hCAFE0000 | (k % 4));
            chk("rr_out_valid", a_out_valid, 1);
        end

        // Backpressure on held ch1 word; rr_ptr=2
        a_out_ready = 1'b0;
        #1 chk("bp_in_ready0", a_in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_out_sel",   a_out_sel, 1);
            chk("bp_out_data",  a_out_data, 32'hCAFE0001);
            chk("bp_out_valid", a_out_valid, 1);
            chk("bp_in_ready",  a_in_ready, 0);
        end
        a_out_ready = 1'b1;
        #1 chk("bp_rel_in_ready", a_in_ready, 4'b0100);
        step();
        chk("bp_rel_out_sel",  a_out_sel, 2);
        chk("bp_rel_out_data", a_out_data, 32'hCAFE0002);

        // Sparse valid with wrap; rr_ptr=3
        a_in_valid = 4'b0010;
        #1 chk("sp_in_ready1", a_in_ready, 4'b0010);
        step();
        chk("sp_out_sel1", a_out_sel, 1);
        a_in_valid = 4'b1001;
        #1 chk("sp_in_ready3", a_in_ready, 4'b1000);
        step();
        chk("sp_out_sel3", a_out_sel, 3);
        a_in_valid = 4'b0011;
        #1 chk("sp_wrap_in_ready", a_in_ready, 4'b0001);
        step();
        chk("sp_wrap_out_sel", a_out_sel, 0);

        // Idle cycle: rr_ptr (=1) holds, output data holds
        a_in_valid = 4'b0000;
        #1 chk("idle_in_ready", a_in_ready, 0);
        step();
        chk("idle_out_valid", a_out_valid, 0);
        chk("idle_out_data",  a_out_data, 32'hCAFE0000);
        a_in_valid = 4'b1111;
        #1 chk("idle_resume_in_ready", a_in_ready, 4'b0010);

        // Mode change takes effect in the same cycle's grant
        a_mode = 1'b0;
        a_sel  = 2'd3;
        #1 chk("mode_in_ready", a_in_ready, 4'b1000);
        step();
        chk("mode_out_sel", a_out_sel, 3);
        chk("mode_out_valid", a_out_valid, 1);

        // Reset mid-stream between edges
        a_mode = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", a_out_valid, 0);
        chk("mrst_out_sel",   a_out_sel, 0);
        chk("mrst_out_data",  a_out_data, 0);
        chk("mrst_in_ready",  a_in_ready, 0);
        #1 rst_n = 1'b1;
        #1 chk("mrst_rel_in_ready", a_in_ready, 4'b0001);
        step();
        chk("mrst_rel_out_sel",   a_out_sel, 0);
        chk("mrst_rel_out_valid", a_out_valid, 1);
        chk("mrst_rel_out_data",  a_out_data, 32'hCAFE0000);

        // 3-channel instance: b has been streaming ch1 in fixed mode since reset release
        chk("b_fix_out_sel",  b_out_sel, 1);
        chk("b_fix_out_data", b_out_data, 8'hA1);
        b_out_ready = 1'b0;
        b_sel       = 2'd3;
        #1 chk("b_oor_in_ready_bp", b_in_ready, 0);
        step();
        chk("b_oor_held_valid", b_out_valid, 1);
        chk("b_oor_held_data",  b_out_data, 8'hA1);
        b_out_ready = 1'b1;
        #1 chk("b_oor_in_ready", b_in_ready, 0);
        step();
        chk("b_oor_drained_valid", b_out_valid, 0);
        chk("b_oor_drained_data",  b_out_data, 8'hA1);

        // Mod-3 round-robin wrap from rr_ptr=0
        b_mode = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk("b_rr_in_ready", b_in_ready, 3'b001 << (k % 3));
            step();
            chk("b_rr_out_sel",  b_out_sel, k % 3);
            chk("b_rr_out_data", b_out_data, 8'hA0 | 8'(k % 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
